// File: rtl/score_bcd_to_binary.sv
// Sequential blanked-BCD to binary decoder: eight digits, MSD first, one per clock.
// Leading blanks (4'hA) are skipped. Embedded blanks, a blank D0 and codes B-F set err_out.
module score_bcd_to_binary (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start,
    input  logic [31:0] bcd_in,
    output logic [26:0] bin_out,
    output logic        valid_out,
    output logic        err_out,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [3:0] BLANK = 4'hA;

    logic [1:0]  state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [26:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        seen_q, seen_d;
    logic        error_q, error_d;
    logic [26:0] bin_q, bin_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [3:0]  digit;
    logic [26:0] acc_x10;

    assign digit   = shift_q[31:28];
    // acc*10 as (acc<<3)+(acc<<1); legal input never exceeds 27 bits
    assign acc_x10 = {acc_q[23:0], 3'b000} + {acc_q[25:0], 1'b0};

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        error_d = error_q;
        bin_d   = bin_q;
        valid_d = 1'b0;
        err_d   = err_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = bcd_in;
                    acc_d   = '0;
                    error_d = 1'b0;
                    cnt_d   = 3'd7;
                    seen_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                shift_d = {shift_q[27:0], 4'h0};
                cnt_d   = cnt_q - 3'd1;
                if (digit <= 4'd9) begin
                    acc_d  = acc_x10 + {23'd0, digit};
                    seen_d = 1'b1;
                end else if (digit == BLANK && !seen_q && cnt_q != 3'd0) begin
                    acc_d = acc_q;
                end else begin
                    error_d = 1'b1;
                end
                if (cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bin_d   = error_q ? '0 : acc_q;
                err_d   = error_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            error_q <= 1'b0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            error_q <= error_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bin_out   = bin_q;
    assign valid_out = valid_q;
    assign err_out   = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_score_bcd_to_binary.sv
// Directed bench for score_bcd_to_binary: legal and malformed words, held start, mid-run reset.
module tb_score_bcd_to_binary;

    logic        clk_in;
    logic        rst_n_in;
    logic        start;
    logic [31:0] bcd_in;
    logic [26:0] bin_out;
    logic        valid_out;
    logic        err_out;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    score_bcd_to_binary dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .start     (start),
        .bcd_in    (bcd_in),
        .bin_out   (bin_out),
        .valid_out (valid_out),
        .err_out   (err_out),
        .busy      (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Full conversion: accept at edge k, checks busy/valid every cycle through k+10
    task automatic convert(input string name, input logic [31:0] word,
                           input logic [26:0] exp_bin, input logic exp_err);
        bcd_in = word;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bcd_in = 32'hFFFF_FFFF;
        check({name, "_busy_k"}, {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check({name, "_busy_run"}, {31'd0, busy}, 32'd1);
            check({name, "_valid_run"}, {31'd0, valid_out}, 32'd0);
        end
        tick();
        check({name, "_valid_k9"}, {31'd0, valid_out}, 32'd1);
        check({name, "_busy_k9"}, {31'd0, busy}, 32'd0);
        check({name, "_bin"}, {5'd0, bin_out}, {5'd0, exp_bin});
        check({name, "_err"}, {31'd0, err_out}, {31'd0, exp_err});
        tick();
        check({name, "_valid_k10"}, {31'd0, valid_out}, 32'd0);
        check({name, "_bin_hold"}, {5'd0, bin_out}, {5'd0, exp_bin});
        $display("conv %s word=%08h bin=%0d err=%0b", name, word, bin_out, err_out);
    endtask

    int valid_count;

    initial begin
        rst_n_in = 1'b0;
        start    = 1'b0;
        bcd_in   = 32'h0;
        #12;
        check("rst_bin", {5'd0, bin_out}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_err", {31'd0, err_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n_in = 1'b1;
        tick();

        convert("zero",    32'hAAAA_AAA0, 27'd0,        1'b0);
        convert("n1234",   32'hAAAA_1234, 27'h4D2,      1'b0);
        convert("max",     32'h9999_9999, 27'h5F5_E0FF, 1'b0);
        convert("embblank",32'hAA1A_2345, 27'd0,        1'b1);
        convert("n1234b",  32'hAAAA_1234, 27'h4D2,      1'b0);
        convert("illegal", 32'h0000_000B, 27'd0,        1'b1);
        convert("allblank",32'hAAAA_AAAA, 27'd0,        1'b1);

        // start held high; word changes after capture
        valid_count = 0;
        bcd_in = 32'h0000_0042;
        start  = 1'b1;
        tick();
        check("held_busy_k", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (i == 3) bcd_in = 32'h0000_0099;
            if (i == 18) start = 1'b0;
            if (valid_out) valid_count++;
            if (i == 9) begin
                check("held_valid_k9", {31'd0, valid_out}, 32'd1);
                check("held_bin_42", {5'd0, bin_out}, 32'd42);
                check("held_err_42", {31'd0, err_out}, 32'd0);
            end
            if (i == 10) begin
                check("held_busy_k10", {31'd0, busy}, 32'd1);
                check("held_valid_k10", {31'd0, valid_out}, 32'd0);
            end
            if (i == 19) begin
                check("held_valid_k19", {31'd0, valid_out}, 32'd1);
                check("held_bin_99", {5'd0, bin_out}, 32'd99);
            end
        end
        check("held_valid_count", valid_count, 32'd2);
        $display("conv held bin=%0d valid_pulses=%0d", bin_out, valid_count);
        tick();
        check("held_idle_busy", {31'd0, busy}, 32'd0);

        // reset mid-conversion
        bcd_in = 32'h0000_0777;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 1; i <= 3; i++) tick();
        rst_n_in = 1'b0;
        #1;
        check("midrst_bin", {5'd0, bin_out}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, valid_out}, 32'd0);
        check("midrst_err", {31'd0, err_out}, 32'd0);
        valid_count = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (valid_out) valid_count++;
        end
        rst_n_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_out) valid_count++;
        end
        check("midrst_no_valid", valid_count, 32'd0);
        check("midrst_idle_busy", {31'd0, busy}, 32'd0);
        $display("reset mid-conversion bin=%0d busy=%0b", bin_out, busy);

        convert("after_rst", 32'hAAAA_A500, 27'd500, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_bcd_to_binary.md
# score_bcd_to_binary

Sequential decoder for the blanked-BCD score word that the display path's BCD incrementer produces. It converts the 8-digit word into a plain binary value, one digit per cycle, most significant digit first. Leading-zero blank codes (4'hA) are accepted and malformed words are flagged. It sits beside the score display and feeds binary consumers such as the high-score compare and level/speed logic, using the same start/busy handshake as the incrementer.

## Interface
- No parameters; word width (8 digits × 4 bits) and output width (27 bits) are fixed.
- clk_in  input  1  system clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcd_in  input  32  blanked-BCD word; D7 = [31:28] … D0 = [3:0]; digit codes 0–9 or 4'hA = blank.
- bin_out  output  27  converted value, 0 … 99_999_999; held between conversions.
- valid_out  output  1  one-cycle pulse when bin_out/err_out are updated.
- err_out  output  1  malformed-input flag for the last conversion; held with bin_out.
- busy  output  1  high from the accepted start until the result cycle.

## Operation
- States: IDLE, CONVERT, DONE.
- IDLE: on start=1, capture bcd_in into a shift register, clear acc (27 b), clear the internal error flag, set the digit counter to 7, set seen_digit=0, busy<=1, and go to CONVERT. When start=0, remain in IDLE.
- CONVERT (8 cycles, D7 first): take the top nibble d, shift the register left by 4, and decrement the counter.
  - d in 0–9: acc <= acc*10 + d, where acc*10 = (acc<<3)+(acc<<1), truncated to 27 b (cannot overflow for legal input). Set seen_digit=1.
  - d = 4'hA with seen_digit=0 and counter≠0 (leading blank): acc unchanged.
  - d = 4'hA with seen_digit=1 (embedded blank), or in D0: set the error flag; acc unchanged.
  - d in 4'hB–4'hF: set the error flag; acc unchanged.
  - After D0 is processed, go to DONE.
- DONE: bin_out <= error ? 0 : acc; err_out <= error; valid_out <= 1; busy <= 0; go to IDLE.
- valid_out is cleared on the next edge. bin_out and err_out hold until the next DONE.
- start while busy is ignored. bcd_in changes after capture have no effect.
- A leading digit of 0 (e.g. 0000_0042) is legal and decodes normally.

## Timing
- Reset (async assert, any state): bin_out=0, valid_out=0, err_out=0, busy=0, state=IDLE, acc=0.
- A reset asserted mid-conversion aborts it. No valid_out pulse is produced and the outputs go to their reset values immediately.
- Deassertion of reset is taken synchronously to clk_in by the surrounding design. The first start is accepted on the first edge after deassertion.
- start is accepted at edge k. busy=1 after edge k. Digits are processed at edges k+1 … k+8. DONE occurs at edge k+9: valid_out=1, busy=0, outputs updated. valid_out=0 after edge k+10.
- Fixed latency: 9 cycles from start to valid_out, independent of digit content and errors.
- Back-to-back: the earliest next start is accepted at edge k+10 (IDLE). Maximum throughput is one conversion per 10 cycles.
- With start held high continuously, conversions are accepted at k, k+10, k+20, …

## Test plan
- bcd_in=32'hAAAA_AAA0, start pulse at k → valid_out at k+9, bin_out=0, err_out=0; busy high over k+1…k+9.
- bcd_in=32'hAAAA_1234 → bin_out=1234 (27'h4D2), err_out=0. Then bcd_in=32'h9999_9999 → bin_out=99_999_999 (27'h5F5_E0FF).
- Malformed words, each gives err_out=1, bin_out=0, still at k+9: 32'hAA1A_2345 (embedded blank); 32'h0000_000B (illegal code); 32'hAAAA_AAAA (blank D0).
- start held high with bcd_in=32'h0000_0042, and bcd_in changed to 32'h0000_0099 at k+3 → first result 42 at k+9. The second conversion is accepted at k+10 and gives 99 at k+19. No extra valid pulses.
- Start at k, rst_n_in asserted low at k+4 for 2 cycles → all outputs 0 immediately, no valid pulse. A new start after release converts 32'hAAAA_A500 → 500.
